frame_fetch_sched: RTL

// - Bus master for the line reader's video-memory read port (vm_*). Replaces direct host reads.
// - Each completed line is fetched as LINE_WORDS 64-bit words: 4 pixels per word.
// - Each completed histogram is fetched as HISTO_WORDS words: 2 bins per word.
// - Fetched words are streamed to a valid/ready consumer (DMA/FIFO).
// - Both jobs share the single vm port; line jobs are scheduled ahead of histogram jobs.

---
 rtl/frame_fetch_sched.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/frame_fetch_sched.sv
// frame_fetch_sched
//   Bus master for the line reader's video-memory read port. When the reader
//   finishes a line (status_which_line toggles) or a histogram
//   (status_which_histo toggles), the completed half is fetched word by word
//   over vm_* and streamed to a valid/ready consumer.
//   Line jobs take priority over histogram jobs. A job is never preempted.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   status_which_line        reader's current line write half
//   status_which_histo       reader's current histogram half
//   vm_address[8:0]          {kind, half, word index}
//   vm_bus_enable, vm_rw     read request strobe (vm_rw mirrors vm_bus_enable)
//   vm_acknowledge           read data valid this cycle
//   vm_read_data[63:0]       read data
//   out_data/out_valid/out_ready  consumer stream
//   out_kind                 0 = line word, 1 = histogram word
//   out_first/out_last       first/last word of the job (qualified by out_valid)
//   busy                     job in progress
//   overrun_count[7:0]       saturating count of dropped jobs
//
// Optional build macro FETCH_TIMEOUT_EN: abort a request that goes
// ACK_TIMEOUT cycles without an acknowledge.
module frame_fetch_sched #(
  parameter int LINE_WORDS  = 128,
  parameter int HISTO_WORDS = 128,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        status_which_line,
  input  logic        status_which_histo,
  output logic [8:0]  vm_address,
  output logic        vm_bus_enable,
  output logic        vm_rw,
  input  logic        vm_acknowledge,
  input  logic [63:0] vm_read_data,
  output logic [63:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_kind,
  output logic        out_first,
  output logic        out_last,
  output logic        busy,
  output logic [7:0]  overrun_count
);

  typedef enum logic [1:0] {IDLE, REQ, OUT} state_t;

  localparam logic [6:0] LINE_LAST  = 7'(LINE_WORDS - 1);
  localparam logic [6:0] HISTO_LAST = 7'(HISTO_WORDS - 1);

  state_t     state_reg;
  logic       line_prev_reg, histo_prev_reg;
  logic       line_pend_reg, histo_pend_reg;
  logic       line_half_reg, histo_half_reg;
  logic       job_half_reg;
  logic [6:0] idx_reg;

  logic       line_tog, histo_tog;
  logic       line_take, histo_take;
  logic       line_ovr, histo_ovr;
  logic       timeout_abort;
  logic       is_last;
  logic [1:0] ovr_inc;
  logic [8:0] ovr_sum;

  assign line_tog   = status_which_line != line_prev_reg;
  assign histo_tog  = status_which_histo != histo_prev_reg;
  assign line_take  = (state_reg == IDLE) && line_pend_reg;
  assign histo_take = (state_reg == IDLE) && !line_pend_reg && histo_pend_reg;
  // A toggle only drops a job if the previous one of that kind is still
  // pending and is not being picked up in this very cycle.
  assign line_ovr   = line_tog && line_pend_reg && !line_take;
  assign histo_ovr  = histo_tog && histo_pend_reg && !histo_take;
  assign is_last    = idx_reg == (out_kind ? HISTO_LAST : LINE_LAST);

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] to_cnt_reg;
  assign timeout_abort = (state_reg == REQ) && !vm_acknowledge &&
                         (to_cnt_reg == TW'(ACK_TIMEOUT - 1));
`else
  assign timeout_abort = 1'b0;
`endif

  assign ovr_inc = {1'b0, line_ovr} + {1'b0, histo_ovr} + {1'b0, timeout_abort};
  assign ovr_sum = {1'b0, overrun_count} + {7'd0, ovr_inc};

  assign vm_rw     = vm_bus_enable;
  assign busy      = state_reg != IDLE;
  assign out_first = out_valid && (idx_reg == 7'd0);
  assign out_last  = out_valid && is_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      // Load the current status so reset itself never looks like a toggle.
      line_prev_reg  <= status_which_line;
      histo_prev_reg <= status_which_histo;
      line_pend_reg  <= 1'b0;
      histo_pend_reg <= 1'b0;
      line_half_reg  <= 1'b0;
      histo_half_reg <= 1'b0;
      job_half_reg   <= 1'b0;
      idx_reg        <= 7'd0;
      vm_address     <= 9'd0;
      vm_bus_enable  <= 1'b0;
      out_data       <= 64'd0;
      out_valid      <= 1'b0;
      out_kind       <= 1'b0;
      overrun_count  <= 8'd0;
`ifdef FETCH_TIMEOUT_EN
      to_cnt_reg     <= '0;
`endif
    end else begin
      line_prev_reg  <= status_which_line;
      histo_prev_reg <= status_which_histo;

      // The completed half is the one the reader just left.
      if (line_tog) begin
        line_pend_reg <= 1'b1;
        line_half_reg <= !status_which_line;
      end else if (line_take) begin
        line_pend_reg <= 1'b0;
      end

      if (histo_tog) begin
        histo_pend_reg <= 1'b1;
        histo_half_reg <= !status_which_histo;
      end else if (histo_take) begin
        histo_pend_reg <= 1'b0;
      end

      overrun_count <= ovr_sum[8] ? 8'hFF : ovr_sum[7:0];

      case (state_reg)
        IDLE: begin
          if (line_take || histo_take) begin
            out_kind      <= histo_take;
            job_half_reg  <= histo_take ? histo_half_reg : line_half_reg;
            idx_reg       <= 7'd0;
            vm_bus_enable <= 1'b1;
            vm_address    <= {histo_take, (histo_take ? histo_half_reg : line_half_reg), 7'd0};
            state_reg     <= REQ;
`ifdef FETCH_TIMEOUT_EN
            to_cnt_reg    <= '0;
`endif
          end
        end
        REQ: begin
          if (vm_acknowledge) begin
            out_data      <= vm_read_data;
            out_valid     <= 1'b1;
            vm_bus_enable <= 1'b0;
            state_reg     <= OUT;
          end else if (timeout_abort) begin
            vm_bus_enable <= 1'b0;
            state_reg     <= IDLE;
          end
`ifdef FETCH_TIMEOUT_EN
          else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
`endif
        end
        OUT: begin
          // The request is already low here, giving the reader its idle cycle.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (is_last) begin
              state_reg <= IDLE;
            end else begin
              idx_reg       <= idx_reg + 7'd1;
              vm_bus_enable <= 1'b1;
              vm_address    <= {out_kind, job_half_reg, idx_reg + 7'd1};
              state_reg     <= REQ;
`ifdef FETCH_TIMEOUT_EN
              to_cnt_reg    <= '0;
`endif
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
